// File: rtl/sum_nb_serial_pkg.sv
// Shared encodings for the bit-serial adder/subtractor: FSM states and op codes.
package sum_nb_serial_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/sum_nb_serial_full_adder_1b.sv
// Single combinational full-adder cell shared by every bit of a serial operation.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/sum_nb_serial.sv
// Bit-serial WIDTH-bit add/subtract, LSB first, one bit per clock through one
// full-adder cell; results held from done until the next accepted start.
module sum_nb_serial
  import sum_nb_serial_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             cin,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic             V
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cy_q, cy_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             fa_s, fa_co;
  logic             accept;

  full_adder_1b u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (cy_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Starts are honoured in IDLE and DONE so back-to-back operations need no gap.
  assign accept = start && (state_q != ST_RUN);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cy_d    = cy_q;
    c_d     = c_q;
    v_d     = v_q;
    case (state_q)
      ST_RUN: begin
        s_d   = {fa_s, s_q[WIDTH-1:1]};
        cy_d  = fa_co;
        a_d   = {1'b0, a_q[WIDTH-1:1]};
        b_d   = {1'b0, b_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // cy_q is the carry into the MSB on this last bit.
          c_d     = fa_co;
          v_d     = cy_q ^ fa_co;
          cnt_d   = cnt_q;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept) begin
      a_d     = A;
      b_d     = B ^ {WIDTH{op}};
      cy_d    = (op == OP_SUB) ? 1'b1 : cin;
      cnt_d   = '0;
      s_d     = '0;
      c_d     = 1'b0;
      v_d     = 1'b0;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cy_q    <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cy_q    <= cy_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign S    = s_q;
  assign C    = c_q;
  assign V    = v_q;

endmodule

// File: tb/tb_sum_nb_serial.sv
// Directed bench for sum_nb_serial at WIDTH 8, 16 and 2 with hand-computed results.
module tb_sum_nb_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic op  = 1'b0;
  logic cin = 1'b0;

  logic        start8 = 1'b0, busy8, done8, c8, v8;
  logic [7:0]  a8 = '0, b8 = '0, s8;
  logic        start16 = 1'b0, busy16, done16, c16, v16;
  logic [15:0] a16 = '0, b16 = '0, s16;
  logic        start2 = 1'b0, busy2, done2, c2, v2;
  logic [1:0]  a2 = '0, b2 = '0, s2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sum_nb_serial #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op), .cin(cin), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .S(s8), .C(c8), .V(v8)
  );
  sum_nb_serial #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op), .cin(cin), .A(a16), .B(b16),
    .busy(busy16), .done(done16), .S(s16), .C(c16), .V(v16)
  );
  sum_nb_serial #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .op(op), .cin(cin), .A(a2), .B(b2),
    .busy(busy2), .done(done2), .S(s2), .C(c2), .V(v2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch8(input logic [7:0] a, input logic [7:0] b, input logic o, input logic c);
    a8 = a; b8 = b; op = o; cin = c; start8 = 1'b1;
    step();
    start8 = 1'b0;
    chk("launch_busy", {31'd0, busy8}, 32'd1);
    chk("launch_done", {31'd0, done8}, 32'd0);
  endtask

  // pre = edges after the accepting edge before the one that raises done.
  task automatic finish8(input string tag, input int pre, input logic [7:0] es,
                         input logic ec, input logic ev);
    repeat (pre) step();
    chk({tag, "_not_early"}, {31'd0, done8}, 32'd0);
    step();
    chk({tag, "_done"}, {31'd0, done8}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy8}, 32'd0);
    chk({tag, "_S"}, {24'd0, s8}, {24'd0, es});
    chk({tag, "_C"}, {31'd0, c8}, {31'd0, ec});
    chk({tag, "_V"}, {31'd0, v8}, {31'd0, ev});
    step();
    chk({tag, "_pulse"}, {31'd0, done8}, 32'd0);
    chk({tag, "_hold"}, {24'd0, s8}, {24'd0, es});
  endtask

  initial begin
    logic saw_done;

    repeat (2) step();
    chk("rst_busy", {31'd0, busy8}, 32'd0);
    chk("rst_done", {31'd0, done8}, 32'd0);
    chk("rst_S", {24'd0, s8}, 32'd0);
    chk("rst_C", {31'd0, c8}, 32'd0);
    chk("rst_V", {31'd0, v8}, 32'd0);
    rst = 1'b0;
    step();

    launch8(8'h3A, 8'h05, 1'b0, 1'b0);
    finish8("add", 7, 8'h3F, 1'b0, 1'b0);
    launch8(8'hFF, 8'h01, 1'b0, 1'b0);
    finish8("add_ff", 7, 8'h00, 1'b1, 1'b0);
    launch8(8'h7F, 8'h01, 1'b0, 1'b0);
    finish8("add_7f", 7, 8'h80, 1'b0, 1'b1);
    launch8(8'h10, 8'h20, 1'b0, 1'b1);
    finish8("add_cin", 7, 8'h31, 1'b0, 1'b0);
    launch8(8'h07, 8'h05, 1'b1, 1'b0);
    finish8("sub_pos", 7, 8'h02, 1'b1, 1'b0);
    launch8(8'h05, 8'h07, 1'b1, 1'b1);
    finish8("sub_neg", 7, 8'hFE, 1'b0, 1'b0);
    launch8(8'h80, 8'h01, 1'b1, 1'b0);
    finish8("sub_ovf", 7, 8'h7F, 1'b1, 1'b1);

    // Start with new operands during RUN must be ignored.
    launch8(8'h3A, 8'h05, 1'b0, 1'b0);
    repeat (3) step();
    a8 = 8'hAA; b8 = 8'h11; op = 1'b1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    chk("ign_busy", {31'd0, busy8}, 32'd1);
    finish8("ign", 3, 8'h3F, 1'b0, 1'b0);

    // Start held high through DONE: next op launches with no IDLE cycle.
    a8 = 8'h10; b8 = 8'h20; op = 1'b0; cin = 1'b1; start8 = 1'b1;
    step();
    chk("b2b_busy0", {31'd0, busy8}, 32'd1);
    repeat (7) step();
    chk("b2b_not_early", {31'd0, done8}, 32'd0);
    step();
    chk("b2b_done1", {31'd0, done8}, 32'd1);
    chk("b2b_S1", {24'd0, s8}, 32'h31);
    a8 = 8'h07; b8 = 8'h05; op = 1'b1; cin = 1'b0;
    step();
    start8 = 1'b0;
    chk("b2b_busy1", {31'd0, busy8}, 32'd1);
    chk("b2b_done_lo", {31'd0, done8}, 32'd0);
    chk("b2b_S_clr", {24'd0, s8}, 32'd0);
    finish8("b2b2", 7, 8'h02, 1'b1, 1'b0);

    // Asynchronous reset mid-operation.
    launch8(8'h3A, 8'h05, 1'b0, 1'b0);
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy8}, 32'd0);
    chk("mid_rst_done", {31'd0, done8}, 32'd0);
    chk("mid_rst_S", {24'd0, s8}, 32'd0);
    chk("mid_rst_C", {31'd0, c8}, 32'd0);
    chk("mid_rst_V", {31'd0, v8}, 32'd0);
    step();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      saw_done = saw_done | done8;
    end
    chk("mid_rst_no_done", {31'd0, saw_done}, 32'd0);
    launch8(8'h3A, 8'h05, 1'b0, 1'b0);
    finish8("post_rst", 7, 8'h3F, 1'b0, 1'b0);

    // WIDTH=16
    a16 = 16'h123A; b16 = 16'h0F05; op = 1'b0; cin = 1'b0; start16 = 1'b1;
    step();
    start16 = 1'b0;
    chk("w16_busy", {31'd0, busy16}, 32'd1);
    repeat (15) step();
    chk("w16_not_early", {31'd0, done16}, 32'd0);
    step();
    chk("w16_done", {31'd0, done16}, 32'd1);
    chk("w16_S", {16'd0, s16}, 32'h213F);
    chk("w16_C", {31'd0, c16}, 32'd0);
    chk("w16_V", {31'd0, v16}, 32'd0);

    a16 = 16'h8FFF; b16 = 16'h7001; start16 = 1'b1;
    step();
    start16 = 1'b0;
    repeat (16) step();
    chk("w16b_done", {31'd0, done16}, 32'd1);
    chk("w16b_S", {16'd0, s16}, 32'h0000);
    chk("w16b_C", {31'd0, c16}, 32'd1);

    // WIDTH=2
    a2 = 2'b01; b2 = 2'b01; op = 1'b0; cin = 1'b0; start2 = 1'b1;
    step();
    start2 = 1'b0;
    chk("w2_busy", {31'd0, busy2}, 32'd1);
    step();
    chk("w2_not_early", {31'd0, done2}, 32'd0);
    step();
    chk("w2_done", {31'd0, done2}, 32'd1);
    chk("w2_S", {30'd0, s2}, 32'd2);
    chk("w2_C", {31'd0, c2}, 32'd0);
    chk("w2_V", {31'd0, v2}, 32'd1);

    a2 = 2'b11; b2 = 2'b11; cin = 1'b1; start2 = 1'b1;
    step();
    start2 = 1'b0;
    repeat (2) step();
    chk("w2b_done", {31'd0, done2}, 32'd1);
    chk("w2b_S", {30'd0, s2}, 32'd3);
    chk("w2b_C", {31'd0, c2}, 32'd1);
    chk("w2b_V", {31'd0, v2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
